// File: rtl/pcie_tx_req_arbiter.sv
// pcie_tx_req_arbiter: round-robin scheduler of the completion, posted-write
// and non-posted-read TX request queues onto the single TRN transmit path.
// One TLP is in flight at a time. A watchdog aborts a grant whose TX engine
// never reports completion, and an outstanding-read budget limits how many
// non-posted reads can be in flight.
module pcie_tx_req_arbiter #(
  parameter int unsigned MAX_RD_OUTSTANDING = 16,
  parameter int unsigned TIMEOUT_CYCLES     = 4096
) (
  input  logic       pcie_clk,
  input  logic       rst,
  input  logic       bus_master_en,
  input  logic [3:0] trn_tbuf_av,
  input  logic       cm_q_req_v,
  input  logic       wr_q_req_v,
  input  logic       rd_q_req_v,
  output logic       cm_q_req_grant,
  output logic       wr_q_req_grant,
  output logic       rd_q_req_grant,
  input  logic       tx_done,
  input  logic       rd_cpl_done,
  output logic [1:0] sel,
  output logic       busy,
  output logic [4:0] rd_outstanding,
  output logic       protocol_err
);

  localparam int unsigned    WDW     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]     RD_MAX  = 5'(MAX_RD_OUTSTANDING);
  localparam logic [1:0]     SEL_NONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_ACTIVE
  } state_t;

  state_t         state;
  logic [1:0]     last;
  logic [WDW-1:0] wd_cnt;
  logic [2:0]     elig;
  logic           win_v;
  logic [1:0]     win;
  logic           cpl_underflow;

  // Per-source eligibility, indexed by source id (0=cm, 1=wr, 2=rd)
  always_comb begin
    elig[0] = cm_q_req_v & trn_tbuf_av[2];
    elig[1] = wr_q_req_v & trn_tbuf_av[1] & bus_master_en;
    elig[2] = rd_q_req_v & trn_tbuf_av[0] & bus_master_en &
              (rd_outstanding < RD_MAX);
  end

  // Round-robin search starting one past the last winner, wrapping mod 3
  always_comb begin
    int unsigned idx;
    logic [1:0]  idx2;
    win_v = 1'b0;
    win   = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      idx  = (32'(last) + 32'd1 + i) % 32'd3;
      idx2 = 2'(idx);
      if (!win_v && elig[idx2]) begin
        win_v = 1'b1;
        win   = idx2;
      end
    end
  end

  // A read tag retired while none are outstanding (and none being added)
  always_comb begin
    cpl_underflow = rd_cpl_done & ~rd_q_req_grant & (rd_outstanding == '0);
  end

  // Grant FSM with registered grant/sel/busy, watchdog and sticky error flag
  always_ff @(posedge pcie_clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      last           <= 2'd2;
      wd_cnt         <= '0;
      cm_q_req_grant <= 1'b0;
      wr_q_req_grant <= 1'b0;
      rd_q_req_grant <= 1'b0;
      sel            <= SEL_NONE;
      busy           <= 1'b0;
      protocol_err   <= 1'b0;
    end else begin
      cm_q_req_grant <= 1'b0;
      wr_q_req_grant <= 1'b0;
      rd_q_req_grant <= 1'b0;
      if (cpl_underflow) protocol_err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (tx_done) protocol_err <= 1'b1;
          if (win_v) begin
            cm_q_req_grant <= (win == 2'd0);
            wr_q_req_grant <= (win == 2'd1);
            rd_q_req_grant <= (win == 2'd2);
            sel            <= win;
            busy           <= 1'b1;
            last           <= win;
            state          <= ST_GRANT;
          end else begin
            sel  <= SEL_NONE;
            busy <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (tx_done) protocol_err <= 1'b1;
          wd_cnt <= '0;
          state  <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (tx_done || (wd_cnt == WD_LAST)) begin
            if (!tx_done) protocol_err <= 1'b1;
            sel   <= SEL_NONE;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            wd_cnt <= wd_cnt + WDW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outstanding-read counter: +1 on the rd grant pulse, -1 per retired tag
  always_ff @(posedge pcie_clk) begin
    if (rst) begin
      rd_outstanding <= '0;
    end else if (rd_q_req_grant && !rd_cpl_done) begin
      rd_outstanding <= rd_outstanding + 5'd1;
    end else if (!rd_q_req_grant && rd_cpl_done && (rd_outstanding != '0)) begin
      rd_outstanding <= rd_outstanding - 5'd1;
    end
  end

endmodule

// File: tb/tb_pcie_tx_req_arbiter.sv
// Directed bench for pcie_tx_req_arbiter with a grant scoreboard: each test
// pushes the source it expects to be granted, and a monitor pops and checks
// on every grant pulse. Built with a read budget of 2 and an 8-cycle watchdog.
module tb_pcie_tx_req_arbiter;

  logic       pcie_clk = 1'b0;
  logic       rst;
  logic       bus_master_en;
  logic [3:0] trn_tbuf_av;
  logic       cm_q_req_v, wr_q_req_v, rd_q_req_v;
  logic       cm_q_req_grant, wr_q_req_grant, rd_q_req_grant;
  logic       tx_done, rd_cpl_done;
  logic [1:0] sel;
  logic       busy;
  logic [4:0] rd_outstanding;
  logic       protocol_err;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned exp_q[$];

  always #5 pcie_clk = ~pcie_clk;

  pcie_tx_req_arbiter #(
    .MAX_RD_OUTSTANDING(2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .pcie_clk(pcie_clk),
    .rst(rst),
    .bus_master_en(bus_master_en),
    .trn_tbuf_av(trn_tbuf_av),
    .cm_q_req_v(cm_q_req_v),
    .wr_q_req_v(wr_q_req_v),
    .rd_q_req_v(rd_q_req_v),
    .cm_q_req_grant(cm_q_req_grant),
    .wr_q_req_grant(wr_q_req_grant),
    .rd_q_req_grant(rd_q_req_grant),
    .tx_done(tx_done),
    .rd_cpl_done(rd_cpl_done),
    .sel(sel),
    .busy(busy),
    .rd_outstanding(rd_outstanding),
    .protocol_err(protocol_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges, then settle 1 time unit past the edge
  task automatic step(input int n);
    repeat (n) @(posedge pcie_clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_master_en = 1'b0; trn_tbuf_av = 4'h0;
    cm_q_req_v = 1'b0; wr_q_req_v = 1'b0; rd_q_req_v = 1'b0;
    tx_done = 1'b0; rd_cpl_done = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  // Returns at the first cycle showing a grant pulse, bounded to 20 cycles
  task automatic wait_grant(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (cm_q_req_grant || wr_q_req_grant || rd_q_req_grant) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    step(1);
    tx_done = 1'b0;
  endtask

  // Scoreboard monitor: every grant pulse must match the next expected source
  always @(negedge pcie_clk) begin
    if (!rst && (cm_q_req_grant || wr_q_req_grant || rd_q_req_grant)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_grant", 32'({rd_q_req_grant, wr_q_req_grant, cm_q_req_grant}), 32'd0);
      end else begin
        int unsigned e;
        e = exp_q.pop_front();
        chk("grant_sel", 32'(sel), e);
        chk("grant_onehot", 32'({rd_q_req_grant, wr_q_req_grant, cm_q_req_grant}), 32'd1 << e);
      end
    end
  end

  initial begin
    // Reset values
    do_reset();
    step(1);
    chk("rst_grants", 32'({rd_q_req_grant, wr_q_req_grant, cm_q_req_grant}), 32'd0);
    chk("rst_sel", 32'(sel), 32'd3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_out", 32'(rd_outstanding), 32'd0);
    chk("rst_err", 32'(protocol_err), 32'd0);

    // Single source: cm grant next cycle, held until tx_done
    trn_tbuf_av = 4'h7;
    cm_q_req_v = 1'b1;
    exp_q.push_back(0);
    step(1);
    chk("single_grant", 32'(cm_q_req_grant), 32'd1);
    chk("single_busy", 32'(busy), 32'd1);
    cm_q_req_v = 1'b0;
    step(1);
    chk("single_grant_drop", 32'(cm_q_req_grant), 32'd0);
    chk("single_sel_hold", 32'(sel), 32'd0);
    step(3);
    chk("single_busy_hold", 32'(busy), 32'd1);
    pulse_tx_done();
    chk("single_sel_done", 32'(sel), 32'd3);
    chk("single_busy_done", 32'(busy), 32'd0);
    chk("single_err", 32'(protocol_err), 32'd0);

    // Round-robin over all three sources
    do_reset();
    bus_master_en = 1'b1; trn_tbuf_av = 4'h7;
    cm_q_req_v = 1'b1; wr_q_req_v = 1'b1; rd_q_req_v = 1'b1;
    for (int k = 0; k < 6; k++) exp_q.push_back(k % 3);
    for (int k = 0; k < 6; k++) begin
      wait_grant("rr_wait");
      step(1);
      chk("rr_rd_out", 32'(rd_outstanding), 32'((k + 1) / 3));
      step(1);
      pulse_tx_done();
    end
    cm_q_req_v = 1'b0; wr_q_req_v = 1'b0; rd_q_req_v = 1'b0;
    chk("rr_rd_out_final", 32'(rd_outstanding), 32'd2);

    // Read budget of 2, then one retired tag allows exactly one more
    do_reset();
    bus_master_en = 1'b1; trn_tbuf_av = 4'h7;
    rd_q_req_v = 1'b1;
    exp_q.push_back(2); exp_q.push_back(2);
    for (int k = 0; k < 2; k++) begin
      wait_grant("budget_wait");
      step(2);
      pulse_tx_done();
    end
    step(10);
    chk("budget_full", 32'(rd_outstanding), 32'd2);
    chk("budget_idle", 32'(busy), 32'd0);
    exp_q.push_back(2);
    rd_cpl_done = 1'b1;
    step(1);
    rd_cpl_done = 1'b0;
    chk("budget_retire", 32'(rd_outstanding), 32'd1);
    wait_grant("budget_regrant");
    step(2);
    pulse_tx_done();
    chk("budget_refill", 32'(rd_outstanding), 32'd2);
    rd_q_req_v = 1'b0;
    step(3);

    // Gating: bus master off, then completion buffer unavailable
    do_reset();
    bus_master_en = 1'b0; trn_tbuf_av = 4'h7;
    wr_q_req_v = 1'b1; rd_q_req_v = 1'b1;
    step(5);
    chk("gate_bme", 32'(busy), 32'd0);
    cm_q_req_v = 1'b1; trn_tbuf_av = 4'h3;
    step(5);
    chk("gate_tbuf", 32'(busy), 32'd0);
    trn_tbuf_av = 4'h7;
    exp_q.push_back(0);
    step(1);
    chk("gate_cm_grant", 32'(cm_q_req_grant), 32'd1);
    cm_q_req_v = 1'b0;
    step(2);
    pulse_tx_done();
    wr_q_req_v = 1'b0; rd_q_req_v = 1'b0;

    // Watchdog: wr grant never completed
    do_reset();
    bus_master_en = 1'b1; trn_tbuf_av = 4'h7;
    wr_q_req_v = 1'b1;
    exp_q.push_back(1);
    wait_grant("wd_wait");
    wr_q_req_v = 1'b0;
    step(8);
    chk("wd_err_before", 32'(protocol_err), 32'd0);
    chk("wd_busy_before", 32'(busy), 32'd1);
    step(1);
    chk("wd_err_after", 32'(protocol_err), 32'd1);
    chk("wd_busy_after", 32'(busy), 32'd0);
    chk("wd_sel_after", 32'(sel), 32'd3);
    cm_q_req_v = 1'b1;
    exp_q.push_back(0);
    wait_grant("wd_next_wait");
    cm_q_req_v = 1'b0;
    step(2);
    pulse_tx_done();
    chk("wd_err_sticky", 32'(protocol_err), 32'd1);

    // Error paths: retire at zero, and tx_done while idle
    do_reset();
    rd_cpl_done = 1'b1;
    step(1);
    rd_cpl_done = 1'b0;
    chk("underflow_cnt", 32'(rd_outstanding), 32'd0);
    chk("underflow_err", 32'(protocol_err), 32'd1);
    do_reset();
    pulse_tx_done();
    chk("idle_txdone_err", 32'(protocol_err), 32'd1);

    // rd grant coincident with a retired tag at count 1
    do_reset();
    bus_master_en = 1'b1; trn_tbuf_av = 4'h7;
    rd_q_req_v = 1'b1;
    exp_q.push_back(2); exp_q.push_back(2);
    wait_grant("coinc_wait1");
    step(2);
    pulse_tx_done();
    chk("coinc_pre", 32'(rd_outstanding), 32'd1);
    wait_grant("coinc_wait2");
    rd_q_req_v = 1'b0;
    rd_cpl_done = 1'b1;
    step(1);
    rd_cpl_done = 1'b0;
    chk("coinc_cnt", 32'(rd_outstanding), 32'd1);
    chk("coinc_err", 32'(protocol_err), 32'd0);
    step(1);
    pulse_tx_done();

    // Reset during an active grant aborts it
    cm_q_req_v = 1'b1;
    exp_q.push_back(0);
    wait_grant("abort_wait");
    cm_q_req_v = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sel", 32'(sel), 32'd3);
    step(4);
    chk("abort_idle", 32'(busy), 32'd0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pcie_tx_req_arbiter.md
Name: pcie_tx_req_arbiter

Overview:
Schedules the three PCIe TX request queues onto the single TRN transmit datapath, one TLP at a time, in pcie_clk. The three queues are completions (cm), posted memory writes (wr) and non-posted memory reads (rd). Eligibility is gated by core buffer availability (trn_tbuf_av), bus-master enable and an outstanding-read budget. Fairness is round-robin, and a watchdog covers a TX engine that never reports completion.

Parameters:
MAX_RD_OUTSTANDING, 16, maximum non-posted reads in flight (one per tag); range 1..16
TIMEOUT_CYCLES, 4096, ACTIVE-state cycles before the watchdog aborts a grant; minimum 2

Ports:
pcie_clk  in  1  sole clock
rst  in  1  synchronous, active-high reset
bus_master_en  in  1  cfg_command[2], registered upstream
trn_tbuf_av  in  4  [0] non-posted, [1] posted, [2] completion buffer available
cm_q_req_v  in  1  completion request pending
wr_q_req_v  in  1  write request pending
rd_q_req_v  in  1  read request pending
cm_q_req_grant  out  1  one-cycle grant pulse
wr_q_req_grant  out  1  one-cycle grant pulse
rd_q_req_grant  out  1  one-cycle grant pulse
tx_done  in  1  TX engine finished the granted TLP (one-cycle pulse)
rd_cpl_done  in  1  RX side retired a read tag (final completion received)
sel  out  2  granted source: 0=cm, 1=wr, 2=rd, 3=none
busy  out  1  grant in progress
rd_outstanding  out  5  reads in flight
protocol_err  out  1  sticky error flag

Behaviour:
- Reset values: all grants 0, sel=3, busy=0, rd_outstanding=0, protocol_err=0. The round-robin pointer last is reset to 2, so cm has first priority. State resets to IDLE.
- Reset asserted mid-grant aborts the grant immediately. No tx_done is expected afterwards.
- Eligibility, evaluated combinationally each cycle:
  - cm_elig = cm_q_req_v & trn_tbuf_av[2]
  - wr_elig = wr_q_req_v & trn_tbuf_av[1] & bus_master_en
  - rd_elig = rd_q_req_v & trn_tbuf_av[0] & bus_master_en & (rd_outstanding < MAX_RD_OUTSTANDING)
- Round-robin: search order starts at last+1 mod 3 and wraps (0→1→2→0). The first eligible source wins.
- FSM states: IDLE, GRANT, ACTIVE.
  - IDLE: if any source is eligible in cycle N, then in cycle N+1 the winner's grant=1 (registered, exactly one cycle), sel=winner, busy=1, last=winner, state=GRANT. Otherwise stay in IDLE with sel=3.
  - GRANT: grants drop to 0 and the state moves to ACTIVE. sel and busy hold.
  - ACTIVE: if tx_done=1, the state moves to IDLE next cycle; sel=3 and busy=0 in that cycle. The earliest next grant is one cycle later, so back-to-back TLPs have a 3-cycle grant spacing minimum.
- Requesters drop or advance their req_v on the grant cycle. The arbiter does not sample req_v outside IDLE.
- tx_done seen in IDLE or GRANT is ignored and sets protocol_err.
- Watchdog:
  - A counter clears on entering ACTIVE and increments every ACTIVE cycle.
  - On reaching TIMEOUT_CYCLES-1 without tx_done: protocol_err=1 and the state returns to IDLE as if tx_done had occurred.
  - If a rd grant times out, its rd_outstanding increment is not undone.
- rd_outstanding rules:
  - Increments in the rd grant cycle; decrements on rd_cpl_done.
  - Both in the same cycle: value unchanged.
  - rd_cpl_done at 0: stays 0 and protocol_err=1.
  - The counter never exceeds MAX_RD_OUTSTANDING, guaranteed by the eligibility gate.
- Mid-operation changes: bus_master_en or trn_tbuf_av dropping does not revoke an issued grant. These inputs only affect the next arbitration.
- protocol_err clears only on rst.

Test Plan:
- Single source: after reset, assert cm_q_req_v=1 with tbuf_av=4'h7 at cycle 0 → cm_q_req_grant=1 in cycle 1 only, sel=0 and busy=1 until tx_done. Pulse tx_done at cycle 5 → sel=3 and busy=0 at cycle 6.
- Round-robin: all three queues continuously requesting, tbuf_av=4'h7, bus_master_en=1, tx_done 2 cycles after each grant → grant order cm, wr, rd, cm, wr, rd. rd_outstanding rises by 1 per rd grant.
- Read budget: MAX_RD_OUTSTANDING=2, only rd requesting, no rd_cpl_done → exactly 2 rd grants, then none. A single rd_cpl_done pulse → one more grant follows and rd_outstanding returns to 2.
- Gating: bus_master_en=0 with wr and rd requesting → no grants. With cm also requesting and tbuf_av[2]=0 → no grant. Setting tbuf_av[2]=1 → cm grant on the next cycle.
- Watchdog: TIMEOUT_CYCLES=8, wr granted, tx_done never asserted → after 8 ACTIVE cycles protocol_err=1 and the FSM returns to IDLE. A following cm request is granted normally.
- Error paths: rd_cpl_done with rd_outstanding=0 → counter stays 0 and protocol_err=1. rd grant coincident with rd_cpl_done at count 1 → count stays 1.
